// File: rtl/bfly_rq.sv
// Requantizer for butterfly-twiddle products: <6.13> -> <4.6> with round-half-up and
// saturation, behind a main + skid register pair, with saturation statistics.
module bfly_rq #(
  parameter int BFLY  = 10,
  parameter int TW    = 9,
  parameter int WIDTH = BFLY + TW,
  parameter int N     = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   in_re,
  input  logic [N*WIDTH-1:0]   in_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*BFLY-1:0]    out_re,
  output logic [N*BFLY-1:0]    out_im,
  input  logic                 sat_clr,
  output logic                 sat_flag,
  output logic [15:0]          sat_cnt
);

  // state | meaning
  // EMPTY | main and skid empty
  // ONE   | main holds a vector, skid empty
  // TWO   | main and skid both hold a vector, in_ready low
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_TWO   = 2'b11;

  localparam int FRAC = TW - 2;
  localparam int RW   = WIDTH + 1 - FRAC;
  localparam int VW   = N * BFLY;
  localparam logic signed [WIDTH:0] HALF = (WIDTH + 1)'(1 << (FRAC - 1));
  localparam logic signed [RW-1:0]  MAXV = RW'((1 << (BFLY - 1)) - 1);
  localparam logic signed [RW-1:0]  MINV = RW'(-(1 << (BFLY - 1)));

  // Returns {saturated, value}; the extra sign bit keeps the +HALF from overflowing.
  function automatic logic [BFLY:0] rq_lane(input logic [WIDTH-1:0] x);
    logic signed [WIDTH:0] s;
    logic signed [RW-1:0]  r;
    s = $signed({x[WIDTH-1], x}) + HALF;
    r = RW'(s >>> FRAC);
    if (r > MAXV)      rq_lane = {1'b1, MAXV[BFLY-1:0]};
    else if (r < MINV) rq_lane = {1'b1, MINV[BFLY-1:0]};
    else               rq_lane = {1'b0, r[BFLY-1:0]};
  endfunction

  logic            main_valid_q, main_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic [VW-1:0]   main_re_q, main_re_d, main_im_q, main_im_d;
  logic [VW-1:0]   skid_re_q, skid_re_d, skid_im_q, skid_im_d;
  logic            sat_flag_q, sat_flag_d;
  logic [15:0]     sat_cnt_q, sat_cnt_d;

  logic [VW-1:0]   rq_re, rq_im;
  logic            any_sat;
  logic            accept, xfer;
  logic [1:0]      state;
  logic [BFLY:0]   lane_re, lane_im;

  always_comb begin
    rq_re   = '0;
    rq_im   = '0;
    any_sat = 1'b0;
    lane_re = '0;
    lane_im = '0;
    for (int i = 0; i < N; i++) begin
      lane_re = rq_lane(in_re[i*WIDTH +: WIDTH]);
      lane_im = rq_lane(in_im[i*WIDTH +: WIDTH]);
      rq_re[i*BFLY +: BFLY] = lane_re[BFLY-1:0];
      rq_im[i*BFLY +: BFLY] = lane_im[BFLY-1:0];
      any_sat = any_sat | lane_re[BFLY] | lane_im[BFLY];
    end
  end

  assign accept = in_valid && !skid_valid_q;
  assign xfer   = main_valid_q && out_ready;
  assign state  = {main_valid_q, skid_valid_q};

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_re_d    = main_re_q;
    main_im_d    = main_im_q;
    skid_re_d    = skid_re_q;
    skid_im_d    = skid_im_q;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          main_valid_d = 1'b1;
          main_re_d    = rq_re;
          main_im_d    = rq_im;
        end
      end
      ST_ONE: begin
        if (accept && xfer) begin
          main_re_d = rq_re;
          main_im_d = rq_im;
        end else if (accept) begin
          skid_valid_d = 1'b1;
          skid_re_d    = rq_re;
          skid_im_d    = rq_im;
        end else if (xfer) begin
          main_valid_d = 1'b0;
        end
      end
      ST_TWO: begin
        if (xfer) begin
          skid_valid_d = 1'b0;
          main_re_d    = skid_re_q;
          main_im_d    = skid_im_q;
        end
      end
      default: begin
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
      end
    endcase
  end

  // Clear wins over a same-cycle saturating accept.
  always_comb begin
    sat_flag_d = sat_flag_q;
    sat_cnt_d  = sat_cnt_q;
    if (sat_clr) begin
      sat_flag_d = 1'b0;
      sat_cnt_d  = '0;
    end else if (accept && any_sat) begin
      sat_flag_d = 1'b1;
      if (sat_cnt_q != 16'hFFFF) sat_cnt_d = sat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_re_q    <= '0;
      main_im_q    <= '0;
      skid_re_q    <= '0;
      skid_im_q    <= '0;
      sat_flag_q   <= 1'b0;
      sat_cnt_q    <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_re_q    <= main_re_d;
      main_im_q    <= main_im_d;
      skid_re_q    <= skid_re_d;
      skid_im_q    <= skid_im_d;
      sat_flag_q   <= sat_flag_d;
      sat_cnt_q    <= sat_cnt_d;
    end
  end

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_re    = main_re_q;
  assign out_im    = main_im_q;
  assign sat_flag  = sat_flag_q;
  assign sat_cnt   = sat_cnt_q;

endmodule
